// File: rtl/muldiv_iter_pkg.sv
// Shared types for the iterative multiply/divide engine: op encoding, FSM states
// and counter sizing.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SIGN,
    ST_DONE
  } muldiv_state_t;

  localparam int DEFAULT_WIDTH = 32;

  // Iteration counter width, $clog2(WIDTH), kept at least 1 bit wide.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic logic op_is_signed(input muldiv_op_t op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface muldiv_iter_if #(
  parameter int WIDTH = muldiv_pkg::DEFAULT_WIDTH
);
  import muldiv_pkg::*;

  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             annul;
  logic             ready;
  logic             busy;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b, annul,
    input  ready, busy, result_valid, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b, annul,
    output ready, busy, result_valid, hi, lo, div_zero
  );

endinterface

// File: rtl/muldiv_iter_twos_neg.sv
// Conditional two's-complement negate: y = en ? -x : x.
// Latency: combinational.
// Backpressure: none.
module twos_neg #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  assign y = en ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_iter.sv
// Radix-2 iterative signed/unsigned multiply/divide engine producing {hi, lo}.
// Latency: WIDTH+1 cycles from accepted start to the one-cycle result_valid pulse.
// Backpressure: start taken only while ready; busy stalls the pipe; annul cancels.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_iter_if.slave bus
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  muldiv_op_t       op_q;
  logic [WIDTH-1:0] a_raw_q, mag_b_q, hi_q, lo_q;
  logic [W2-1:0]    acc_q, acc_step;
  logic             res_neg_q, rem_neg_q, dz_q;

  logic             ready, accept, calc_last, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, quo_fix, rem_fix;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH:0]   add_x, add_y, add_sum;
  logic             add_cin;

  assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept    = ready && bus.start && !bus.annul;
  assign calc_last = (cnt_q == CNT_LAST);
  assign is_div    = op_is_div(op_q);
  assign a_neg     = op_is_signed(bus.op) && bus.a[WIDTH-1];
  assign b_neg     = op_is_signed(bus.op) && bus.b[WIDTH-1];

  twos_neg #(.W(WIDTH)) u_mag_a (.en(a_neg), .x(bus.a), .y(mag_a));
  twos_neg #(.W(WIDTH)) u_mag_b (.en(b_neg), .x(bus.b), .y(mag_b));
  twos_neg #(.W(W2))    u_prod  (.en(res_neg_q), .x(acc_q), .y(prod_fix));
  twos_neg #(.W(WIDTH)) u_quo   (.en(res_neg_q), .x(acc_q[WIDTH-1:0]), .y(quo_fix));
  twos_neg #(.W(WIDTH)) u_rem   (.en(rem_neg_q), .x(acc_q[W2-1:WIDTH]), .y(rem_fix));

  // One adder serves both ops: add multiplicand to the high half, or trial-subtract
  // the divisor from the partial remainder shifted left by one.
  always_comb begin
    add_x   = {1'b0, acc_q[W2-1:WIDTH]};
    add_y   = {1'b0, mag_b_q};
    add_cin = 1'b0;
    if (is_div) begin
      add_x   = acc_q[W2-1:WIDTH-1];
      add_y   = ~{1'b0, mag_b_q};
      add_cin = 1'b1;
    end
    add_sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};
  end

  always_comb begin
    acc_step = acc_q;
    if (is_div) begin
      if (add_sum[WIDTH])
        acc_step = {acc_q[W2-2:0], 1'b0};
      else
        acc_step = {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else if (acc_q[0]) begin
      acc_step = {add_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[W2-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: state_d = (bus.start && !bus.annul) ? ST_CALC : ST_IDLE;
      ST_CALC:          state_d = bus.annul ? ST_IDLE : (calc_last ? ST_SIGN : ST_CALC);
      ST_SIGN:          state_d = bus.annul ? ST_IDLE : ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      op_q      <= OP_MULT;
      a_raw_q   <= '0;
      mag_b_q   <= '0;
      acc_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q     <= '0;
        op_q      <= bus.op;
        a_raw_q   <= bus.a;
        mag_b_q   <= mag_b;
        acc_q     <= {{WIDTH{1'b0}}, mag_a};
        res_neg_q <= a_neg ^ b_neg;
        rem_neg_q <= a_neg;
      end else if (state_q == ST_CALC) begin
        if (bus.annul) begin
          cnt_q <= '0;
        end else begin
          acc_q <= acc_step;
          cnt_q <= calc_last ? '0 : cnt_q + CNT_W'(1);
        end
      end

      // Results land only on the SIGN->DONE edge; an annulled op leaves hi/lo alone.
      if (state_q == ST_SIGN && !bus.annul) begin
        if (!is_div) begin
          {hi_q, lo_q} <= prod_fix;
          dz_q         <= 1'b0;
        end else if (mag_b_q == '0) begin
          hi_q <= a_raw_q;
          lo_q <= '1;
          dz_q <= 1'b1;
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
          dz_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ready        = ready;
  assign bus.busy         = (state_q == ST_CALC) || (state_q == ST_SIGN);
  assign bus.result_valid = (state_q == ST_DONE);
  assign bus.div_zero     = (state_q == ST_DONE) && dz_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32 and WIDTH=8 with hand-computed results.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  muldiv_iter_if #(.WIDTH(32)) m32 ();
  muldiv_iter_if #(.WIDTH(8))  m8 ();

  muldiv_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(m32));
  muldiv_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(m8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle, then scramble the operands to prove they were latched.
  task automatic launch(input bit w8, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    if (w8) begin
      m8.start = 1'b1; m8.op = op; m8.a = a[7:0]; m8.b = b[7:0];
    end else begin
      m32.start = 1'b1; m32.op = op; m32.a = a; m32.b = b;
    end
    @(negedge clk);
    m8.start  = 1'b0; m8.op  = OP_MULTU; m8.a  = 8'h5A;         m8.b  = 8'h00;
    m32.start = 1'b0; m32.op = OP_DIV;   m32.a = 32'h12345678;  m32.b = 32'h0;
  endtask

  // Sample each negedge until result_valid (bounded); returns positioned on the pulse cycle.
  task automatic collect(input bit w8, output int lat, output int bn,
                         output logic [31:0] h, output logic [31:0] l, output logic dz);
    lat = -1; bn = 0; h = '0; l = '0; dz = 1'b0;
    for (int c = 0; c <= 60; c++) begin
      if (w8 ? m8.result_valid : m32.result_valid) begin
        lat = c;
        h   = w8 ? 32'(m8.hi) : m32.hi;
        l   = w8 ? 32'(m8.lo) : m32.lo;
        dz  = w8 ? m8.div_zero : m32.div_zero;
        break;
      end
      if (w8 ? m8.busy : m32.busy) bn++;
      @(negedge clk);
    end
  endtask

  task automatic run_check(input bit w8, input string tag, input muldiv_op_t op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int lat, bn;
    logic [31:0] h, l;
    logic dz;
    int exp_lat;
    exp_lat = w8 ? 9 : 33;
    launch(w8, op, a, b);
    collect(w8, lat, bn, h, l, dz);
    chk({tag, ".lat"},  64'(lat), 64'(exp_lat));
    chk({tag, ".busy"}, 64'(bn),  64'(exp_lat));
    chk({tag, ".hi"},   64'(h),   64'(eh));
    chk({tag, ".lo"},   64'(l),   64'(el));
    chk({tag, ".dz"},   64'(dz),  64'(edz));
    @(negedge clk);
    chk({tag, ".pulse"}, 64'(w8 ? m8.result_valid : m32.result_valid), 64'd0);
  endtask

  task automatic no_result(input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (m32.result_valid) seen++;
      @(negedge clk);
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int lat, bn;
    logic [31:0] h, l;
    logic dz;

    m32.start = 1'b0; m32.op = OP_MULT; m32.a = '0; m32.b = '0; m32.annul = 1'b0;
    m8.start  = 1'b0; m8.op  = OP_MULT; m8.a  = '0; m8.b  = '0; m8.annul  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready", 64'(m32.ready),        64'd1);
    chk("rst.busy",  64'(m32.busy),         64'd0);
    chk("rst.rv",    64'(m32.result_valid), 64'd0);
    chk("rst.dz",    64'(m32.div_zero),     64'd0);
    chk("rst.hi",    64'(m32.hi),           64'd0);
    chk("rst.lo",    64'(m32.lo),           64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_check(0, "mult_neg",   OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_check(0, "mult_nn",    OP_MULT,  32'hFFFFFFFB, 32'hFFFFFFF9, 32'h0,        32'd35,       1'b0);

    // MULTU then DIVU issued in the DONE cycle, no bubble between them.
    launch(0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    collect(0, lat, bn, h, l, dz);
    chk("multu.lat", 64'(lat), 64'd33);
    chk("multu.hi",  64'(h),   64'hFFFFFFFE);
    chk("multu.lo",  64'(l),   64'h00000001);
    launch(0, OP_DIVU, 32'd100, 32'd7);
    chk("b2b.busy_now", 64'(m32.busy), 64'd1);
    collect(0, lat, bn, h, l, dz);
    chk("b2b.lat", 64'(lat), 64'd33);
    chk("b2b.hi",  64'(h),   64'd2);
    chk("b2b.lo",  64'(l),   64'd14);
    @(negedge clk);

    run_check(0, "div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_check(0, "div_ovf",    OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
    run_check(0, "divu_z",     OP_DIVU, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1);
    run_check(0, "div_z",      OP_DIV,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    run_check(0, "div_7_m2",   OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);

    // Annul ten cycles into CALC: back to IDLE, hi/lo keep the previous result.
    launch(0, OP_MULTU, 32'd5, 32'd6);
    repeat (10) @(negedge clk);
    m32.annul = 1'b1;
    @(negedge clk);
    m32.annul = 1'b0;
    chk("annul.busy",  64'(m32.busy),  64'd0);
    chk("annul.ready", 64'(m32.ready), 64'd1);
    no_result("annul.no_rv");
    chk("annul.hi", 64'(m32.hi), 64'd1);
    chk("annul.lo", 64'(m32.lo), 64'hFFFFFFFD);

    m32.start = 1'b1; m32.annul = 1'b1; m32.op = OP_MULTU; m32.a = 32'd2; m32.b = 32'd3;
    @(negedge clk);
    m32.start = 1'b0; m32.annul = 1'b0;
    chk("start_annul.busy", 64'(m32.busy), 64'd0);
    no_result("start_annul.no_rv");

    // Annul during DONE: pulse stays, the simultaneous start is dropped.
    launch(0, OP_MULTU, 32'd2, 32'd3);
    collect(0, lat, bn, h, l, dz);
    chk("done_annul.lo", 64'(l), 64'd6);
    m32.annul = 1'b1; m32.start = 1'b1; m32.op = OP_MULTU; m32.a = 32'd4; m32.b = 32'd4;
    #1;
    chk("done_annul.rv", 64'(m32.result_valid), 64'd1);
    @(negedge clk);
    m32.annul = 1'b0; m32.start = 1'b0;
    chk("done_annul.busy", 64'(m32.busy),         64'd0);
    chk("done_annul.rv2",  64'(m32.result_valid), 64'd0);
    chk("done_annul.lo2",  64'(m32.lo),           64'd6);

    // Start while busy with different operands is ignored.
    launch(0, OP_MULTU, 32'd10, 32'd20);
    repeat (4) @(negedge clk);
    m32.start = 1'b1; m32.op = OP_DIVU; m32.a = 32'd99; m32.b = 32'd3;
    @(negedge clk);
    m32.start = 1'b0;
    collect(0, lat, bn, h, l, dz);
    chk("busy_start.lat", 64'(lat), 64'd28);
    chk("busy_start.hi",  64'(h),   64'd0);
    chk("busy_start.lo",  64'(l),   64'd200);
    @(negedge clk);
    chk("busy_start.idle", 64'(m32.busy), 64'd0);

    run_check(1, "w8.mult",  OP_MULT,  32'hFE, 32'h03, 32'hFF, 32'hFA, 1'b0);
    run_check(1, "w8.multu", OP_MULTU, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    run_check(1, "w8.div",   OP_DIV,   32'hF9, 32'h02, 32'hFF, 32'hFD, 1'b0);
    run_check(1, "w8.ovf",   OP_DIV,   32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);
    run_check(1, "w8.divz",  OP_DIVU,  32'h07, 32'h00, 32'h07, 32'hFF, 1'b1);

    // Reset in the middle of CALC returns everything to reset values at once.
    launch(0, OP_MULTU, 32'd3, 32'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.ready", 64'(m32.ready),        64'd1);
    chk("midrst.busy",  64'(m32.busy),         64'd0);
    chk("midrst.rv",    64'(m32.result_valid), 64'd0);
    chk("midrst.hi",    64'(m32.hi),           64'd0);
    chk("midrst.lo",    64'(m32.lo),           64'd0);
    chk("midrst.hi8",   64'(m8.hi),            64'd0);
    @(negedge clk);
    rst = 1'b0;
    no_result("midrst.no_rv");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the execute stage. It replaces the single-cycle multiply and the stall-driven divide handshake in the ALU with one radix-2 sequential engine. The engine supports signed/unsigned MULT and DIV, a start/ready/valid handshake, and pipeline annul. Its result is a `{hi, lo}` pair written to the HI/LO register pair.

## Interface
- `WIDTH`, 32: operand width in bits; must be ≥ 4.
- `clk` in, 1: clock; all state updates on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `start` in, 1: request an operation; accepted only when `ready` = 1.
- `op` in, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a` in, WIDTH: multiplicand or dividend; sampled with `start`.
- `b` in, WIDTH: multiplier or divisor; sampled with `start`.
- `annul` in, 1: synchronous cancel of the in-flight operation (exception or flush).
- `ready` out, 1: unit can accept `start` this cycle.
- `busy` out, 1: operation in progress; the pipeline stalls on this.
- `result_valid` out, 1: one-cycle pulse; `hi`/`lo` are new this cycle.
- `hi` out, WIDTH: product high half, or remainder.
- `lo` out, WIDTH: product low half, or quotient.
- `div_zero` out, 1: qualifies `result_valid`; a divide with `b` = 0 completed.

## Operation
- States:
  - IDLE: `ready` = 1.
  - CALC: `busy` = 1; counter runs 0..WIDTH-1.
  - SIGN: `busy` = 1; final sign correction.
  - DONE: `result_valid` = 1, `ready` = 1.
- Transitions:
  - IDLE/DONE + `start` & !`annul` → CALC, counter = 0.
  - IDLE/DONE otherwise → IDLE.
  - CALC with counter = WIDTH-1 → SIGN.
  - SIGN → DONE.
  - `annul` in CALC or SIGN → IDLE; no `result_valid`; `hi`/`lo` unchanged.
- On accept, the unit latches `op` and the magnitudes of `a`/`b`:
  - Two's-complement absolute value for signed ops, raw value otherwise.
  - It also latches the result sign and the remainder sign (= sign of `a`).
  - Later changes on `a`/`b`/`op` are ignored.
- Multiply: shift-add, one multiplier bit per CALC cycle, into a 2·WIDTH accumulator.
  - SIGN stage negates the full 2·WIDTH product if `a`[MSB] ^ `b`[MSB] (signed only).
- Divide: restoring division, one quotient bit per CALC cycle.
  - SIGN stage negates the quotient if the operand signs differ.
  - It negates the remainder if the dividend is negative.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: `lo` = all ones, `hi` = `a` as latched (original, unsigned-interpreted), `div_zero` = 1. The same latency applies as for any other operation.
- Signed overflow (MIN / −1): `lo` = MIN, `hi` = 0; no flag.
- `hi`/`lo` are registered and written only on entry to DONE. They hold their value until the next completion.

## Timing
- Reset values:
  - state IDLE
  - `ready` 1
  - `busy` 0
  - `result_valid` 0
  - `div_zero` 0
  - `hi` 0
  - `lo` 0
  - counter 0
- Latency: if `start` is accepted at edge k, CALC lasts for edges k+1..k+WIDTH. SIGN follows, and `result_valid` is high for exactly the cycle after edge k+WIDTH+1. For WIDTH = 32 that is WIDTH+1 = 33 cycles after acceptance.
- Back-to-back: `start` during DONE is accepted; the DONE pulse still occurs; no idle bubble.
- `start` while `busy`: ignored, no state change.
- `annul` and `start` in the same cycle: `annul` wins; the start is dropped.
- `annul` in DONE: the pulse already present is not retracted; only the start in that cycle is dropped.
- `rst` mid-operation: immediate return to the reset values; no result is produced.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` (2-bit op encoding above).
  - `muldiv_state_t` (IDLE/CALC/SIGN/DONE).
  - Localparam for counter width `$clog2(WIDTH)`.
- Sub-module `twos_neg`: parametrised-width conditional two's-complement negate. It is used for operand magnitude on accept and for sign correction in SIGN.
- Single datapath:
  - shared 2·WIDTH shift register (accumulator / remainder:quotient)
  - one WIDTH+1-bit adder/subtractor

## Test plan
- MULT `a` = 0xFFFFFFFE, `b` = 3 → `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFFA; `result_valid` exactly 33 cycles after accept; `busy` high for 32+1 cycles.
- MULTU `a` = `b` = 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001. Back-to-back DIVU 100/7 started in the DONE cycle → `lo` = 14, `hi` = 2, with no gap.
- DIV −7/2 (0xFFFFFFF9, 2) → `lo` = 0xFFFFFFFD, `hi` = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → `lo` = 0x80000000, `hi` = 0.
- DIVU 7/0 → `lo` = 0xFFFFFFFF, `hi` = 7, `div_zero` = 1. DIV 0xFFFFFFF9/0 → `hi` = 0xFFFFFFF9.
- `annul` at cycle 10 of CALC → IDLE next edge, no `result_valid`, `hi`/`lo` keep prior values. `start` with `annul` in the same cycle → not accepted.
- Assert `rst` mid-CALC, and also `start` while `busy` with different operands → outputs return to reset values / first result unaffected. Repeat the MULT and DIV checks with `WIDTH` = 8 (e.g. DIV −128/−1 → `lo` = 0x80).
